// File: rtl/poly1305_mac_core_if.sv
// poly1305_mac_core_if: key, block and tag handshakes of the Poly1305 MAC engine.
// The slave side is the engine; the master side is the framer/comparator.
interface poly1305_mac_core_if;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_r;
    logic [127:0] key_s;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
    logic [4:0]   blk_len;
    logic         blk_last;
    logic         tag_valid;
    logic         tag_ready;
    logic [127:0] tag;
    logic         busy;

    modport slave (
        input  key_valid, key_r, key_s,
        input  blk_valid, blk_data, blk_len, blk_last,
        input  tag_ready,
        output key_ready, blk_ready, tag_valid, tag, busy
    );

    modport master (
        output key_valid, key_r, key_s,
        output blk_valid, blk_data, blk_len, blk_last,
        output tag_ready,
        input  key_ready, blk_ready, tag_valid, tag, busy
    );
endinterface

// File: rtl/poly1305_mac_core.sv
// poly1305_mac_core: RFC 8439 Poly1305 tag engine with a digit-serial
// multiplier, block padding, clamping, final reduction and s addition.
module poly1305_mac_core #(
    parameter int DIGIT_W = 8
) (
    input logic               clk,
    input logic               rst_ni,
    poly1305_mac_core_if.slave bus
);

    localparam int N  = 128 / DIGIT_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 132 + DIGIT_W;
    localparam logic [CW-1:0] DLAST = CW'(N - 1);
    localparam logic [127:0] CLAMP =
        128'h0ffffffc0ffffffc0ffffffc0fffffff;
    localparam logic [130:0] P = (131'd1 << 130) - 131'd5;

    typedef enum logic [2:0] {
        IDLE, WAIT_BLK, MUL, RED1, RED2, FINAL, TAG
    } state_e;

    state_e        state_q;
    logic [127:0]  r_q;
    logic [127:0]  s_q;
    logic [130:0]  acc_q;
    logic [131:0]  sum_q;
    logic [255:0]  prod_q;
    logic [130:0]  t_q;
    logic [CW-1:0] dcnt_q;
    logic          last_q;
    logic [127:0]  tag_q;

    logic [4:0]         len_d;
    logic [128:0]       m_d;
    logic [6:0]         sh_d;
    logic [DIGIT_W-1:0] dig_d;
    logic [PW-1:0]      pp_d;
    logic [255:0]       part_d;
    logic [130:0]       t_d;
    logic [130:0]       red_d;
    logic [127:0]       c_d;

    // Pad the offered block: keep L bytes, put 0x01 just above them.
    always_comb begin
        len_d = bus.blk_len;
        if (bus.blk_len == 5'd0 || bus.blk_len > 5'd16) begin
            len_d = 5'd16;
        end
        m_d = '0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < len_d) begin
                m_d[8*i +: 8] = bus.blk_data[8*i +: 8];
            end
        end
        for (int i = 1; i <= 16; i++) begin
            if (5'(i) == len_d) begin
                m_d[8*i] = 1'b1;
            end
        end
    end

    // One digit of r times the padded sum, aligned to its weight.
    always_comb begin
        sh_d   = 7'(dcnt_q) * 7'(DIGIT_W);
        dig_d  = r_q[sh_d +: DIGIT_W];
        pp_d   = PW'(sum_q) * PW'(dig_d);
        part_d = 256'(pp_d) << sh_d;
    end

    // Fold bits above 2^130 back in (2^130 == 5 mod p), then canonicalise.
    always_comb begin
        t_d   = {1'b0, prod_q[129:0]}
              + 131'(prod_q[255:130]) * 131'd5;
        red_d = {1'b0, t_q[129:0]}
              + (t_q[130] ? 131'd5 : 131'd0);
        c_d   = (acc_q >= P) ? 128'(acc_q - P) : acc_q[127:0];
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            r_q     <= '0;
            s_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            prod_q  <= '0;
            t_q     <= '0;
            dcnt_q  <= '0;
            last_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.key_valid) begin
                        r_q     <= bus.key_r & CLAMP;
                        s_q     <= bus.key_s;
                        acc_q   <= '0;
                        state_q <= WAIT_BLK;
                    end
                end
                WAIT_BLK: begin
                    if (bus.blk_valid) begin
                        sum_q   <= {1'b0, acc_q} + {3'b0, m_d};
                        prod_q  <= '0;
                        dcnt_q  <= '0;
                        last_q  <= bus.blk_last;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    prod_q <= prod_q + part_d;
                    dcnt_q <= dcnt_q + CW'(1);
                    if (dcnt_q == DLAST) begin
                        state_q <= RED1;
                    end
                end
                RED1: begin
                    t_q     <= t_d;
                    state_q <= RED2;
                end
                RED2: begin
                    acc_q   <= red_d;
                    state_q <= last_q ? FINAL : WAIT_BLK;
                end
                FINAL: begin
                    tag_q   <= c_d + s_q;
                    state_q <= TAG;
                end
                TAG: begin
                    if (bus.tag_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.key_ready = (state_q == IDLE);
    assign bus.blk_ready = (state_q == WAIT_BLK);
    assign bus.tag_valid = (state_q == TAG);
    assign bus.busy      = (state_q != IDLE);
    assign bus.tag       = tag_q;

endmodule

// File: tb/tb_poly1305_mac_core.sv
// tb_poly1305_mac_core: randomized and directed scoreboard bench for the
// Poly1305 engine, with a wide-arithmetic mod-p reference model.
module tb_poly1305_mac_core;

    localparam logic [259:0] P = (260'd1 << 130) - 260'd5;
    localparam logic [127:0] CLAMP =
        128'h0ffffffc0ffffffc0ffffffc0fffffff;
    localparam logic [127:0] RFC_R =
        128'ha806d542fe52447f336d555778bed685;
    localparam logic [127:0] RFC_S =
        128'h1bf54941aff6bf4afdb20dfb8a800301;
    localparam logic [127:0] RFC_TAG =
        128'ha927010caf8b2bc2c6365130c11d06a8;
    localparam string MSG = "Cryptographic Forum Research Group";

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ni;
    logic rst2_n;
    int   cyc = 0;

    // Cycle counter used for latency and throughput measurements.
    always @(posedge clk) cyc <= cyc + 1;

    poly1305_mac_core_if bus();
    poly1305_mac_core #(.DIGIT_W(8)) dut (
        .clk(clk), .rst_ni(rst_ni), .bus(bus)
    );

    // Two more engines at other radices, driven from small arrays.
    logic [1:0]   kv, bv, sl_last, kr, br;
    logic [127:0] skr [2];
    logic [127:0] sks [2];
    logic [127:0] sd  [2];
    logic [4:0]   sl  [2];

    poly1305_mac_core_if bus1();
    poly1305_mac_core_if bus32();
    poly1305_mac_core #(.DIGIT_W(1)) dut1 (
        .clk(clk), .rst_ni(rst2_n), .bus(bus1)
    );
    poly1305_mac_core #(.DIGIT_W(32)) dut32 (
        .clk(clk), .rst_ni(rst2_n), .bus(bus32)
    );

    assign bus1.key_valid  = kv[0];
    assign bus1.key_r      = skr[0];
    assign bus1.key_s      = sks[0];
    assign bus1.blk_valid  = bv[0];
    assign bus1.blk_data   = sd[0];
    assign bus1.blk_len    = sl[0];
    assign bus1.blk_last   = sl_last[0];
    assign bus1.tag_ready  = 1'b1;
    assign kr[0]           = bus1.key_ready;
    assign br[0]           = bus1.blk_ready;
    assign bus32.key_valid = kv[1];
    assign bus32.key_r     = skr[1];
    assign bus32.key_s     = sks[1];
    assign bus32.blk_valid = bv[1];
    assign bus32.blk_data  = sd[1];
    assign bus32.blk_len   = sl[1];
    assign bus32.blk_last  = sl_last[1];
    assign bus32.tag_ready = 1'b1;
    assign kr[1]           = bus32.key_ready;
    assign br[1]           = bus32.blk_ready;

    int n_chk  = 0;
    int n_pass = 0;
    int srx0   = 0;
    int srx1   = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Reference model: acc = ((acc + m) * r) mod p, tag = acc + s.
    logic [129:0] macc;
    logic [127:0] mr;
    logic [127:0] ms;

    function automatic logic [129:0] mstep(input logic [129:0] a,
            input logic [127:0] rc, input logic [127:0] d,
            input logic [4:0] len);
        logic [259:0] m;
        logic [259:0] x;
        int L;
        L = (len == 0 || len > 16) ? 16 : int'(len);
        m = '0;
        for (int i = 0; i < L; i++) m[8*i +: 8] = d[8*i +: 8];
        m = m + (260'd1 << (8 * L));
        x = ((260'(a) + m) * 260'(rc)) % P;
        return x[129:0];
    endfunction

    function automatic logic [127:0] mtag();
        return 128'(macc[127:0] + ms);
    endfunction

    function automatic logic [127:0] sblk(input int off, input int n);
        logic [127:0] d = '0;
        for (int i = 0; i < n; i++) d[8*i +: 8] = MSG[off + i];
        return d;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] exp_q [$];
    logic [127:0] sq0 [$];
    logic [127:0] sq1 [$];
    int           acc_t [$];
    int           tv_rise = 0;
    logic         tv_prev = 1'b0;

    // Scoreboard monitor: pop and compare on every tag handshake.
    always @(negedge clk) begin
        if (rst_ni && bus.tag_valid && bus.tag_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL tag_unexpected: got %h want none", bus.tag);
            end else begin
                chk("tag_dw8", bus.tag, exp_q.pop_front());
            end
        end
        if (rst2_n && bus1.tag_valid && bus1.tag_ready) begin
            srx0++;
            if (sq0.size() != 0) chk("tag_dw1", bus1.tag, sq0.pop_front());
        end
        if (rst2_n && bus32.tag_valid && bus32.tag_ready) begin
            srx1++;
            if (sq1.size() != 0) chk("tag_dw32", bus32.tag, sq1.pop_front());
        end
        if (rst_ni && bus.blk_valid && bus.blk_ready) acc_t.push_back(cyc);
        if (bus.tag_valid && !tv_prev) tv_rise <= cyc;
        tv_prev <= bus.tag_valid;
    end

    task automatic key_tx(input logic [127:0] r, input logic [127:0] s);
        int n = 0;
        bus.key_r = r;
        bus.key_s = s;
        bus.key_valid = 1'b1;
        @(negedge clk);
        while (!bus.key_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus.key_ready) begin
            n_chk++;
            $display("FAIL key_timeout: key_ready=0 want 1");
        end
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        macc = '0;
        mr = r & CLAMP;
        ms = s;
    endtask

    task automatic blk_tx(input logic [127:0] d, input logic [4:0] len,
                          input logic last, input logic hold);
        int n = 0;
        bus.blk_data = d;
        bus.blk_len = len;
        bus.blk_last = last;
        bus.blk_valid = 1'b1;
        @(negedge clk);
        while (!bus.blk_ready && n < 500) begin @(negedge clk); n++; end
        if (!bus.blk_ready) begin
            n_chk++;
            $display("FAIL blk_timeout: blk_ready=0 want 1");
        end
        @(posedge clk); #1;
        if (!hold) bus.blk_valid = 1'b0;
        macc = mstep(macc, mr, d, len);
    endtask

    task automatic tag_wait();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL tag_timeout: pending %0d want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic drv_sec(input int i);
        int n;
        skr[i] = RFC_R;
        sks[i] = RFC_S;
        kv[i] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!kr[i] && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        kv[i] = 1'b0;
        for (int b = 0; b < 3; b++) begin
            sd[i] = sblk(16 * b, (b == 2) ? 2 : 16);
            sl[i] = (b == 2) ? 5'd2 : 5'd16;
            sl_last[i] = (b == 2);
            bv[i] = 1'b1;
            n = 0;
            @(negedge clk);
            while (!br[i] && n < 1000) begin @(negedge clk); n++; end
            @(posedge clk); #1;
            bv[i] = 1'b0;
        end
        if (i == 0) sq0.push_back(RFC_TAG);
        else sq1.push_back(RFC_TAG);
    endtask

    initial begin
        logic [127:0] e;
        int nb;
        int n;
        bus.key_valid = 1'b0;
        bus.blk_valid = 1'b0;
        bus.key_r = '0;
        bus.key_s = '0;
        bus.blk_data = '0;
        bus.blk_len = '0;
        bus.blk_last = 1'b0;
        bus.tag_ready = 1'b1;
        kv = '0;
        bv = '0;
        sl_last = '0;
        for (int i = 0; i < 2; i++) begin
            skr[i] = '0; sks[i] = '0; sd[i] = '0; sl[i] = '0;
        end
        rst_ni = 1'b0;
        rst2_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        rst2_n = 1'b1;
        fork
            drv_sec(0);
            drv_sec(1);
        join_none

        @(negedge clk);
        chk("rst_key_ready", 128'(bus.key_ready), 128'd1);
        chk("rst_blk_ready", 128'(bus.blk_ready), 128'd0);
        chk("rst_tag_valid", 128'(bus.tag_valid), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_tag", bus.tag, 128'd0);
        @(posedge clk); #1;

        // RFC 8439 vector, junk above L in the short block.
        key_tx(RFC_R, RFC_S);
        chk("blk_ready_after_key", 128'(bus.blk_ready), 128'd1);
        chk("busy_after_key", 128'(bus.busy), 128'd1);
        blk_tx(sblk(0, 16), 5'd16, 1'b0, 1'b0);
        blk_tx(sblk(16, 16), 5'd16, 1'b0, 1'b0);
        blk_tx(sblk(32, 2) | 128'hdeadbeef_cafef00d_12345678_9abc0000,
               5'd2, 1'b1, 1'b0);
        exp_q.push_back(RFC_TAG);
        tag_wait();
        chk("key_ready_after_tag", 128'(bus.key_ready), 128'd1);

        // Final reduction: acc = 2^130-2 >= p.
        key_tx(128'd1, 128'd0);
        blk_tx({128{1'b1}}, 5'd16, 1'b0, 1'b0);
        blk_tx({128{1'b1}}, 5'd16, 1'b1, 1'b0);
        exp_q.push_back(128'd3);
        tag_wait();

        // Padding and masking.
        key_tx(128'd1, 128'd0);
        blk_tx({{15{8'haa}}, 8'h00}, 5'd1, 1'b1, 1'b0);
        exp_q.push_back(128'h100);
        tag_wait();
        key_tx(128'd1, 128'd0);
        blk_tx({128{1'b1}}, 5'd0, 1'b1, 1'b0);
        exp_q.push_back({128{1'b1}});
        tag_wait();

        // Throughput with blk_valid held high over three blocks.
        key_tx(rnd128(), rnd128());
        acc_t.delete();
        blk_tx(rnd128(), 5'd16, 1'b0, 1'b1);
        blk_tx(rnd128(), 5'd9, 1'b0, 1'b1);
        blk_tx(rnd128(), 5'd16, 1'b1, 1'b0);
        exp_q.push_back(mtag());
        tag_wait();
        chk("accepts", 128'(acc_t.size()), 128'd3);
        if (acc_t.size() == 3) begin
            chk("gap01", 128'(acc_t[1] - acc_t[0]), 128'd19);
            chk("gap12", 128'(acc_t[2] - acc_t[1]), 128'd19);
            chk("tag_latency", 128'(tv_rise - acc_t[2]), 128'd20);
        end

        // Backpressure on the tag with stray key/blk pulses.
        key_tx(rnd128(), rnd128());
        blk_tx(rnd128(), 5'($urandom_range(0, 31)), 1'b0, 1'b0);
        bus.tag_ready = 1'b0;
        blk_tx(rnd128(), 5'($urandom_range(0, 31)), 1'b1, 1'b0);
        e = mtag();
        exp_q.push_back(e);
        n = 0;
        while (!bus.tag_valid && n < 200) begin @(negedge clk); n++; end
        chk("bp_tag_valid_rise", 128'(bus.tag_valid), 128'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.key_valid = i[0];
            bus.blk_valid = ~i[0];
            bus.key_r = rnd128();
            bus.blk_data = rnd128();
            @(negedge clk);
            chk("bp_tag_valid", 128'(bus.tag_valid), 128'd1);
            chk("bp_tag", bus.tag, e);
            chk("bp_key_ready", 128'(bus.key_ready), 128'd0);
        end
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        bus.blk_valid = 1'b0;
        bus.tag_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_next", 128'(bus.key_ready), 128'd1);
        chk("bp_tag_held", bus.tag, e);
        tag_wait();

        // Random messages against the model.
        repeat (6) begin
            key_tx(rnd128(), rnd128());
            nb = $urandom_range(1, 4);
            for (int j = 0; j < nb; j++) begin
                blk_tx(rnd128(), 5'($urandom_range(0, 31)),
                       (j == nb - 1), 1'b0);
            end
            exp_q.push_back(mtag());
            tag_wait();
        end

        // Reset during the fifth MUL cycle, then a clean RFC run.
        key_tx(rnd128(), rnd128());
        blk_tx(rnd128(), 5'd16, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mrst_key_ready", 128'(bus.key_ready), 128'd1);
        chk("mrst_blk_ready", 128'(bus.blk_ready), 128'd0);
        chk("mrst_tag_valid", 128'(bus.tag_valid), 128'd0);
        chk("mrst_busy", 128'(bus.busy), 128'd0);
        chk("mrst_tag", bus.tag, 128'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        key_tx(RFC_R, RFC_S);
        blk_tx(sblk(0, 16), 5'd16, 1'b0, 1'b0);
        blk_tx(sblk(16, 16), 5'd16, 1'b0, 1'b0);
        blk_tx(sblk(32, 2), 5'd2, 1'b1, 1'b0);
        exp_q.push_back(RFC_TAG);
        tag_wait();

        // The other radices finish their RFC run.
        n = 0;
        while ((srx0 == 0 || srx1 == 0) && n < 3000) begin
            @(posedge clk); n++;
        end
        @(negedge clk);
        chk("tags_dw1", 128'(srx0), 128'd1);
        chk("tags_dw32", 128'(srx1), 128'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
